// File: rtl/nn_pkg.sv
// Shared types and helpers for the neural-network datapath blocks.
package nn_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} argmax_state_t;

    // Index width that stays legal (>=1 bit) even for a single-entry vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/argmax_classifier.sv
// Sequential argmax over the final-layer score bus: snapshot on start, one signed
// compare per clock, then a one-cycle done pulse with the winning index and value.
module argmax_classifier
    import nn_pkg::*;
#(
    parameter int neuron_number = 10,
    parameter int dataWidth     = 16,
    localparam int IDX_W        = idx_width(neuron_number),
    localparam int SW           = 2 * dataWidth
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [SW*neuron_number-1:0] scores,
    output logic                        busy,
    output logic                        done,
    output logic [IDX_W-1:0]            class_idx,
    output logic signed [SW-1:0]        max_score
);

    localparam logic [IDX_W-1:0] LastCnt = IDX_W'(neuron_number - 1);

    argmax_state_t               state_q, state_d;
    logic [SW*neuron_number-1:0] snap_q, snap_d;
    logic [IDX_W-1:0]            cnt_q, cnt_d;
    logic signed [SW-1:0]        best_val_q, best_val_d;
    logic [IDX_W-1:0]            best_idx_q, best_idx_d;
    logic [IDX_W-1:0]            class_idx_q, class_idx_d;
    logic signed [SW-1:0]        max_score_q, max_score_d;
    logic signed [SW-1:0]        cur_val;
    logic                        accept;

    // Select the snapshot entry addressed by the scan counter.
    always_comb begin
        cur_val = '0;
        for (int i = 0; i < neuron_number; i++) begin
            if (cnt_q == IDX_W'(i)) cur_val = $signed(snap_q[i*SW +: SW]);
        end
    end

    // Next-state: scan step, final result capture and start acceptance.
    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        cnt_d       = cnt_q;
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;
        class_idx_d = class_idx_q;
        max_score_d = max_score_q;
        // A new request may overlap the DONE cycle so scans can run back-to-back.
        accept      = start && (state_q != SCAN);

        unique case (state_q)
            SCAN: begin
                // Strict compare keeps the lowest index on ties.
                if (cur_val > best_val_q) begin
                    best_val_d = cur_val;
                    best_idx_d = cnt_q;
                end
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == LastCnt) begin
                    state_d     = DONE;
                    class_idx_d = best_idx_d;
                    max_score_d = best_val_d;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            snap_d     = scores;
            best_val_d = $signed(scores[SW-1:0]);
            best_idx_d = '0;
            cnt_d      = IDX_W'(1);
            if (neuron_number > 1) begin
                state_d = SCAN;
            end else begin
                state_d     = DONE;
                class_idx_d = '0;
                max_score_d = $signed(scores[SW-1:0]);
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            cnt_q       <= '0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
            class_idx_q <= '0;
            max_score_q <= '0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            cnt_q       <= cnt_d;
            best_val_q  <= best_val_d;
            best_idx_q  <= best_idx_d;
            class_idx_q <= class_idx_d;
            max_score_q <= max_score_d;
        end
    end

    assign busy      = (state_q == SCAN);
    assign done      = (state_q == DONE);
    assign class_idx = class_idx_q;
    assign max_score = max_score_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier with a behavioural argmax reference.
module tb_argmax_classifier;

    localparam int N  = 10;
    localparam int DW = 16;
    localparam int SW = 2 * DW;
    localparam int IW = 4;
    localparam int TMO = 40;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [SW*N-1:0]      scores;
    logic                 busy;
    logic                 done;
    logic [IW-1:0]        class_idx;
    logic signed [SW-1:0] max_score;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    argmax_classifier #(
        .neuron_number (N),
        .dataWidth     (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .scores    (scores),
        .busy      (busy),
        .done      (done),
        .class_idx (class_idx),
        .max_score (max_score)
    );

    // Reference: find the maximum value, then the first index holding it.
    function automatic void ref_argmax(input logic [SW*N-1:0] bus, output int idx,
                                       output logic signed [SW-1:0] val);
        logic signed [SW-1:0] v[N];
        for (int i = 0; i < N; i++) v[i] = bus[i*SW +: SW];
        val = v[0];
        foreach (v[i]) if (v[i] > val) val = v[i];
        idx = -1;
        foreach (v[i]) if (idx < 0 && v[i] == val) idx = i;
    endfunction

    function automatic logic [SW*N-1:0] pack(input int s[N]);
        logic [SW*N-1:0] b;
        for (int i = 0; i < N; i++) b[i*SW +: SW] = s[i];
        return b;
    endfunction

    // Pulse start for one cycle and wait (bounded) for done; returns edges after accept.
    task automatic classify(input logic [SW*N-1:0] bus, output int lat, output logic busy0);
        @(negedge clk);
        scores = bus;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy0 = busy;
        lat   = 0;
        while (done !== 1'b1 && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        int lat;
        logic b0;
        int s[N];
        rst_n  = 1'b0;
        start  = 1'b0;
        scores = '0;
        #1;
        n_vec++;
        if ({busy, done, class_idx, max_score} !== '0) begin
            $display("FAIL reset_init: got busy=%b done=%b idx=%0d val=%0d, want all 0",
                     busy, done, class_idx, max_score);
            n_err++;
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) s[i] = i;
        s[5] = 123;
        classify(pack(s), lat, b0);
        n_vec++;
        if (class_idx !== IW'(5) || max_score !== 123) begin
            $display("FAIL reset_pre: got idx=%0d val=%0d, want idx=5 val=123", class_idx, max_score);
            n_err++;
        end
        // Start another scan and reset it part-way through.
        @(negedge clk);
        scores = pack(s);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, class_idx, max_score} !== '0) begin
            $display("FAIL reset_mid: got busy=%b done=%b idx=%0d val=%0d, want all 0",
                     busy, done, class_idx, max_score);
            n_err++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int dones = 0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (done === 1'b1) dones++;
            end
            n_vec++;
            if (dones != 0) begin
                $display("FAIL reset_no_done: got %0d done pulses, want 0", dones);
                n_err++;
            end
        end
    endtask

    task automatic test_single_max();
        int lat;
        logic b0;
        int s[N];
        for (int i = 0; i < N; i++) s[i] = i * 100;
        s[7] = 5000;
        classify(pack(s), lat, b0);
        n_vec++;
        if (b0 !== 1'b1) begin
            $display("FAIL single_busy: got busy=%b after accept, want 1", b0);
            n_err++;
        end
        n_vec++;
        if (lat != N - 1) begin
            $display("FAIL single_latency: got %0d edges, want %0d", lat, N - 1);
            n_err++;
        end
        n_vec++;
        if (class_idx !== IW'(7) || max_score !== 5000) begin
            $display("FAIL single_result: got idx=%0d val=%0d, want idx=7 val=5000",
                     class_idx, max_score);
            n_err++;
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL single_pulse: got done=%b busy=%b a cycle later, want 0 0", done, busy);
            n_err++;
        end
    endtask

    task automatic test_all_negative();
        int lat;
        logic b0;
        int s[N];
        for (int i = 0; i < N; i++) s[i] = -1000 - 10 * i;
        s[3] = -5;
        classify(pack(s), lat, b0);
        n_vec++;
        if (class_idx !== IW'(3) || max_score !== -5) begin
            $display("FAIL all_negative: got idx=%0d val=%0d, want idx=3 val=-5",
                     class_idx, max_score);
            n_err++;
        end
    endtask

    task automatic test_tie_extremes();
        int lat;
        logic b0;
        int s[N];
        int v;
        for (int i = 0; i < N; i++) s[i] = 32'h8000_0000;
        s[2] = 32'h7FFF_FFFF;
        s[8] = 32'h7FFF_FFFF;
        classify(pack(s), lat, b0);
        n_vec++;
        if (class_idx !== IW'(2) || max_score !== 32'sh7FFF_FFFF) begin
            $display("FAIL tie_extreme: got idx=%0d val=%0d, want idx=2 val=2147483647",
                     class_idx, max_score);
            n_err++;
        end
        v = $urandom;
        for (int i = 0; i < N; i++) s[i] = v;
        classify(pack(s), lat, b0);
        n_vec++;
        if (class_idx !== IW'(0) || max_score !== v) begin
            $display("FAIL all_equal: got idx=%0d val=%0d, want idx=0 val=%0d",
                     class_idx, max_score, v);
            n_err++;
        end
        for (int i = 0; i < N; i++) s[i] = 32'h8000_0000;
        classify(pack(s), lat, b0);
        n_vec++;
        if (class_idx !== IW'(0) || max_score !== 32'sh8000_0000) begin
            $display("FAIL all_min: got idx=%0d val=%0d, want idx=0 val=-2147483648",
                     class_idx, max_score);
            n_err++;
        end
    endtask

    task automatic test_random();
        int lat;
        logic b0;
        int s[N];
        int ei;
        logic signed [SW-1:0] ev;
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < N; i++) begin
                // Narrow ranges force plenty of ties.
                s[i] = (k % 2 == 0) ? int'($urandom) : int'($urandom_range(0, 6)) - 3;
            end
            ref_argmax(pack(s), ei, ev);
            classify(pack(s), lat, b0);
            n_vec++;
            if (lat != N - 1 || class_idx !== IW'(ei) || max_score !== ev) begin
                $display("FAIL random_%0d: got lat=%0d idx=%0d val=%0d, want lat=%0d idx=%0d val=%0d",
                         k, lat, class_idx, max_score, N - 1, ei, ev);
                n_err++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int s[N];
        int ei;
        logic signed [SW-1:0] ev;
        int dones = 0;
        int lat;
        for (int i = 0; i < N; i++) s[i] = $urandom;
        ref_argmax(pack(s), ei, ev);
        @(negedge clk);
        scores = pack(s);
        start  = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            n_vec++;
            if (done === 1'b1) begin
                if (t != 9 + 10 * dones || class_idx !== IW'(ei) || max_score !== ev) begin
                    $display("FAIL b2b_done: at t=%0d got idx=%0d val=%0d, want t=%0d idx=%0d val=%0d",
                             t, class_idx, max_score, 9 + 10 * dones, ei, ev);
                    n_err++;
                end
                dones++;
            end else if (busy !== 1'b1) begin
                $display("FAIL b2b_gap: at t=%0d got busy=%b done=%b, want busy or done", t, busy, done);
                n_err++;
            end
            if (t == 39) start = 1'b0;
        end
        n_vec++;
        if (dones != 4) begin
            $display("FAIL b2b_count: got %0d done pulses, want 4", dones);
            n_err++;
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL b2b_idle: got busy=%b done=%b, want 0 0", busy, done);
            n_err++;
        end
        // Start pulse inside a scan must not disturb it.
        for (int i = 0; i < N; i++) s[i] = i;
        s[1] = 777;
        @(negedge clk);
        scores = pack(s);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        lat   = -1;
        for (int t = 0; t < 25; t++) begin
            if (t == 3) begin
                s[6]   = 9999;
                scores = pack(s);
                start  = 1'b1;
            end
            if (t == 4) start = 1'b0;
            if (done === 1'b1) begin
                dones++;
                if (lat < 0) lat = t;
                n_vec++;
                if (class_idx !== IW'(1) || max_score !== 777) begin
                    $display("FAIL scan_ignore_result: got idx=%0d val=%0d, want idx=1 val=777",
                             class_idx, max_score);
                    n_err++;
                end
            end
            @(negedge clk);
        end
        n_vec++;
        if (dones != 1 || lat != 9) begin
            $display("FAIL scan_ignore_count: got %0d pulses first at t=%0d, want 1 at t=9", dones, lat);
            n_err++;
        end
    endtask

    task automatic test_snapshot();
        int sa[N];
        int sb[N];
        int lat;
        logic b0;
        int bad;
        for (int i = 0; i < N; i++) sa[i] = int'($urandom_range(0, 1000)) - 500;
        sa[6] = 20000;
        sb    = sa;
        sb[4] = 30000;
        @(negedge clk);
        scores = pack(sa);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        scores = pack(sb);
        lat    = 0;
        while (done !== 1'b1 && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat != N - 1 || class_idx !== IW'(6) || max_score !== 20000) begin
            $display("FAIL snapshot_old: got lat=%0d idx=%0d val=%0d, want lat=9 idx=6 val=20000",
                     lat, class_idx, max_score);
            n_err++;
        end
        bad = 0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (class_idx !== IW'(6) || max_score !== 20000) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            $display("FAIL hold_idle: got %0d cycles with changed outputs, want 0", bad);
            n_err++;
        end
        scores = pack(sb);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bad   = 0;
        lat   = 0;
        while (done !== 1'b1 && lat < TMO) begin
            if (class_idx !== IW'(6) || max_score !== 20000) bad++;
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (bad != 0) begin
            $display("FAIL hold_scan: got %0d scan cycles with changed outputs, want 0", bad);
            n_err++;
        end
        n_vec++;
        if (class_idx !== IW'(4) || max_score !== 30000) begin
            $display("FAIL snapshot_new: got idx=%0d val=%0d, want idx=4 val=30000",
                     class_idx, max_score);
            n_err++;
        end
    endtask

    initial begin
        test_reset();
        test_single_max();
        test_all_negative();
        test_tie_extremes();
        test_random();
        test_back_to_back();
        test_snapshot();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
